lift_call_scheduler: RTL and testbench
======================================

// Module: lift_call_scheduler
// PURPOSE
//   Collects floor calls from hall and cabin buttons, picks the next target floor
//   using SCAN (continue current direction, else reverse) and hands it to the lift
//   motion FSM over a valid/ready handshake. Runs the door dwell timer on arrival,
//   then clears the served call. Sits between the button decoders and the lift FSM.
// PARAMETERS
//   N_FLOORS     8   number of floors; floors are numbered 0..N_FLOORS-1
//   FLOOR_W      3   floor index width; must satisfy 2**FLOOR_W >= N_FLOORS
//   DOOR_CYCLES  16  clock cycles the door stays open per stop; minimum 1
// PORTS
//   clk          in   1         clock; all state updates on posedge
//   rst          in   1         reset, asynchronous, active-high
//   call_req     in   N_FLOORS  one-cycle call pulses, one bit per floor; ORed hall+cab
//   cab_floor    in   FLOOR_W   current cabin floor, from the lift FSM
//   cab_arrive   in   1         1-cycle pulse: cabin has stopped at cab_floor
//   tgt_valid    out  1         target floor offered to the lift FSM
//   tgt_floor    out  FLOOR_W   target floor; stable while tgt_valid=1
//   tgt_ready    in   1         lift FSM accepts the target
//   dir_up       out  1         committed travel direction is up (0 = down)
//   door_open    out  1         door dwell active
//   pending      out  N_FLOORS  outstanding calls
//   busy         out  1         FSM state is not IDLE
// BEHAVIOUR
//   Reset: pending=0, tgt_valid=0, tgt_floor=0, dir_up=1, door_open=0, busy=0,
//     door counter=0, state=IDLE.
//   Call latch, every cycle: pending <= (pending | call_req) & ~clear_mask.
//     clear_mask is the served floor's bit, in the cycle DOOR is entered only.
//     A call to cab_floor while in DOOR is not latched; it restarts the dwell counter.
//   States:
//   IDLE: if pending!=0 (registered value) -> SELECT.
//   SELECT: 1 cycle. Compute above = any pending bit > cab_floor, below = any < cab_floor.
//     A pending bit equal to cab_floor -> target=cab_floor, go straight to DOOR.
//     dir_up=1: above -> nearest pending above; else below -> nearest below, dir_up<=0.
//     dir_up=0: mirror of dir_up=1. If pending=0 -> IDLE.
//     Otherwise latch tgt_floor -> DISPATCH.
//   DISPATCH: tgt_valid=1. On tgt_valid&tgt_ready -> MOVING and drop tgt_valid next cycle.
//     tgt_floor must not change while waiting.
//   MOVING: wait for cab_arrive with cab_floor==tgt_floor -> DOOR.
//     cab_arrive at any other floor is ignored; calls there wait for a later SCAN pass.
//   DOOR: door_open=1 for DOOR_CYCLES cycles (counter loads DOOR_CYCLES-1, ends at 0),
//     then SELECT.
//   Latency: call in IDLE at cycle t -> pending at t+1 -> SELECT t+2
//     -> tgt_valid=1 at t+3.
//   New calls arriving during MOVING do not retarget; they are picked up at the next SELECT.
//   Simultaneous call_req set and clear on the same bit: the clear wins.
//   Async rst mid-operation aborts any handshake; tgt_valid falls immediately.
//   cab_floor >= N_FLOORS: SELECT treats both above and below as computed;
//     no pending bit matches it.
// TESTING  (N_FLOORS=8, DOOR_CYCLES=4)
//   Reset, then call_req=8'h20 at cab_floor=0 -> pending=8'h20;
//     tgt_valid=1 with tgt_floor=5 three cycles later; dir_up=1.
//   Hold tgt_ready=0 for 5 cycles -> tgt_valid and tgt_floor=5 stay stable;
//     tgt_ready=1 -> MOVING.
//   cab_arrive with cab_floor=3 -> ignored. Then cab_floor=5 -> door_open=1 for
//     exactly 4 cycles and pending[5] clears.
//   cab_floor=4, dir_up=1, pending=8'h05 -> tgt_floor=2 and dir_up=0;
//     then next target is 0.
//   During DOOR at floor 2, call_req=8'h04 -> not latched; door_open extends
//     to 4 cycles from the call.
//   Assert rst during DISPATCH -> tgt_valid=0, pending=0, busy=0 immediately.

Source files
------------

// File: rtl/lift_call_scheduler_if.sv
// Signal bundle between the call scheduler, the button decoders and the lift motion FSM.
// master = scheduler side (offers targets), slave = buttons + lift FSM side.
interface lift_call_scheduler_if #(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = 3
) ();
  logic [N_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]  cab_floor;
  logic                cab_arrive;
  logic                tgt_valid;
  logic [FLOOR_W-1:0]  tgt_floor;
  logic                tgt_ready;
  logic                dir_up;
  logic                door_open;
  logic [N_FLOORS-1:0] pending;
  logic                busy;

  modport master (
    input  call_req, cab_floor, cab_arrive, tgt_ready,
    output tgt_valid, tgt_floor, dir_up, door_open, pending, busy
  );

  modport slave (
    output call_req, cab_floor, cab_arrive, tgt_ready,
    input  tgt_valid, tgt_floor, dir_up, door_open, pending, busy
  );
endinterface

// File: rtl/lift_call_scheduler.sv
// SCAN-based lift call scheduler: latches floor calls, picks the next target in the
// committed direction, hands it to the lift FSM and runs the door dwell on arrival.
module lift_call_scheduler #(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 16
) (
  input logic                   clk,
  input logic                   rst,
  lift_call_scheduler_if.master bus
);
  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_DISPATCH, S_MOVING, S_DOOR} state_t;

  state_t              state, state_n;
  logic [N_FLOORS-1:0] pending_q, pending_n;
  logic [N_FLOORS-1:0] cab_bit, clear_mask, call_mask;
  logic [FLOOR_W-1:0]  tgt_q, tgt_n;
  logic                dir_q, dir_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                above, below, at_cab;
  logic [FLOOR_W-1:0]  up_floor, dn_floor;

  // Nearest pending floor strictly above / below the cabin; an out-of-range
  // cab_floor simply finds everything below and nothing at or above.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : floor_scan
    cab_bit  = '0;
    above    = 1'b0;
    below    = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && i > int'(bus.cab_floor)) begin
        above    = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i == int'(bus.cab_floor)) cab_bit[i] = 1'b1;
      if (pending_q[i] && i < int'(bus.cab_floor)) begin
        below    = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
    end
  end

  assign at_cab = |(pending_q & cab_bit);

  always_comb begin : fsm_next
    state_n    = state;
    tgt_n      = tgt_q;
    dir_n      = dir_q;
    cnt_n      = cnt_q;
    clear_mask = '0;
    call_mask  = '0;
    unique case (state)
      S_IDLE: if (|pending_q) state_n = S_SELECT;
      S_SELECT: begin
        if (at_cab) begin
          tgt_n      = bus.cab_floor;
          cnt_n      = DOOR_LOAD;
          clear_mask = cab_bit;
          state_n    = S_DOOR;
        end else if (!(|pending_q)) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DISPATCH;
          // Keep going the committed way while anything lies ahead, else reverse.
          if (dir_q ? above : !below) begin
            tgt_n = up_floor;
            dir_n = 1'b1;
          end else begin
            tgt_n = dn_floor;
            dir_n = 1'b0;
          end
        end
      end
      S_DISPATCH: if (bus.tgt_ready) state_n = S_MOVING;
      S_MOVING: begin
        if (bus.cab_arrive && bus.cab_floor == tgt_q) begin
          cnt_n      = DOOR_LOAD;
          clear_mask = cab_bit;
          state_n    = S_DOOR;
        end
      end
      S_DOOR: begin
        // A call for the open floor is absorbed and just holds the door longer.
        call_mask = cab_bit;
        if (|(bus.call_req & cab_bit)) cnt_n = DOOR_LOAD;
        else if (cnt_q == '0)          state_n = S_SELECT;
        else                           cnt_n = cnt_q - CNT_W'(1);
      end
      default: state_n = S_IDLE;
    endcase
    pending_n = (pending_q | (bus.call_req & ~call_mask)) & ~clear_mask;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pending_q <= '0;
      tgt_q     <= '0;
      dir_q     <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state     <= state_n;
      pending_q <= pending_n;
      tgt_q     <= tgt_n;
      dir_q     <= dir_n;
      cnt_q     <= cnt_n;
    end
  end

  assign bus.tgt_valid = (state == S_DISPATCH);
  assign bus.tgt_floor = tgt_q;
  assign bus.dir_up    = dir_q;
  assign bus.door_open = (state == S_DOOR);
  assign bus.pending   = pending_q;
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_lift_call_scheduler.sv
// Bench for lift_call_scheduler: directed walk-through with literal expectations, then
// randomized calls / lift behaviour compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_lift_call_scheduler;
  localparam int N  = 8;
  localparam int FW = 3;
  localparam int D  = 4;

  localparam int M_IDLE = 0, M_SELECT = 1, M_DISPATCH = 2, M_MOVING = 3, M_DOOR = 4;

  typedef struct {
    int           mode;
    logic [N-1:0] pend;
    int           tgt;
    bit           dir;
    int           left;   // door cycles still to show, including the current one
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lift_call_scheduler_if #(.N_FLOORS(N), .FLOOR_W(FW)) bus ();

  lift_call_scheduler #(.N_FLOORS(N), .FLOOR_W(FW), .DOOR_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what the scheduler must do next, from the current inputs and model state.
  function automatic model_t model_next(model_t s);
    model_t n = s;
    int  cf = int'(bus.cab_floor);
    bit  enter_door = 1'b0;
    int  up_pick = -1;
    int  dn_pick = -1;
    for (int f = 0; f < N; f++) begin
      if (s.pend[f] && f > cf && up_pick < 0) up_pick = f;
      if (s.pend[f] && f < cf) dn_pick = f;
    end
    case (s.mode)
      M_IDLE: if (s.pend != '0) n.mode = M_SELECT;
      M_SELECT: begin
        if (cf < N && s.pend[cf]) begin
          n.tgt = cf; n.mode = M_DOOR; n.left = D; enter_door = 1'b1;
        end else if (s.pend == '0) begin
          n.mode = M_IDLE;
        end else begin
          n.mode = M_DISPATCH;
          if (s.dir) begin
            if (up_pick >= 0) n.tgt = up_pick;
            else begin n.tgt = dn_pick; n.dir = 1'b0; end
          end else begin
            if (dn_pick >= 0) n.tgt = dn_pick;
            else begin n.tgt = up_pick; n.dir = 1'b1; end
          end
        end
      end
      M_DISPATCH: if (bus.tgt_ready) n.mode = M_MOVING;
      M_MOVING: if (bus.cab_arrive && cf == s.tgt) begin
        n.mode = M_DOOR; n.left = D; enter_door = 1'b1;
      end
      M_DOOR: begin
        if (cf < N && bus.call_req[cf]) n.left = D;
        else if (s.left == 1)           n.mode = M_SELECT;
        else                            n.left = s.left - 1;
      end
      default: n.mode = M_IDLE;
    endcase
    for (int f = 0; f < N; f++) begin
      if (bus.call_req[f] && !(s.mode == M_DOOR && f == cf)) n.pend[f] = 1'b1;
      if (enter_door && f == cf) n.pend[f] = 1'b0;
    end
    return n;
  endfunction

  model_t m;

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{mode: M_IDLE, pend: '0, tgt: 0, dir: 1'b1, left: 0};
    else     m <= model_next(m);
  end

  always @(negedge clk) begin
    check("tgt_valid", 32'(bus.tgt_valid), 32'(m.mode == M_DISPATCH));
    check("tgt_floor", 32'(bus.tgt_floor), 32'(m.tgt));
    check("dir_up",    32'(bus.dir_up),    32'(m.dir));
    check("door_open", 32'(bus.door_open), 32'(m.mode == M_DOOR));
    check("pending",   32'(bus.pending),   32'(m.pend));
    check("busy",      32'(bus.busy),      32'(m.mode != M_IDLE));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (bus.door_open && n < 20) begin
      n++;
      tick();
    end
  endtask

  int door_len;

  initial begin
    bus.call_req   = '0;
    bus.cab_floor  = '0;
    bus.cab_arrive = 1'b0;
    bus.tgt_ready  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_pending",   32'(bus.pending),   32'h00);
    check("rst_tgt_valid", 32'(bus.tgt_valid), 32'h0);
    check("rst_tgt_floor", 32'(bus.tgt_floor), 32'h0);
    check("rst_dir_up",    32'(bus.dir_up),    32'h1);
    check("rst_door_open", 32'(bus.door_open), 32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Call to floor 5 from floor 0: target offered three cycles after the call.
    bus.cab_floor = 3'd0;
    bus.call_req  = 8'h20;
    tick();
    bus.call_req = '0;
    check("lat_pending", 32'(bus.pending),   32'h20);
    check("lat_valid1",  32'(bus.tgt_valid), 32'h0);
    tick();
    check("lat_valid2",  32'(bus.tgt_valid), 32'h0);
    check("lat_busy2",   32'(bus.busy),      32'h1);
    tick();
    check("lat_valid3",  32'(bus.tgt_valid), 32'h1);
    check("lat_floor3",  32'(bus.tgt_floor), 32'h5);
    check("lat_dir3",    32'(bus.dir_up),    32'h1);

    // Back-pressure: offer stays put.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(bus.tgt_valid), 32'h1);
      check("hold_floor", 32'(bus.tgt_floor), 32'h5);
    end
    bus.tgt_ready = 1'b1;
    tick();
    bus.tgt_ready = 1'b0;
    check("acc_valid", 32'(bus.tgt_valid), 32'h0);
    check("acc_busy",  32'(bus.busy),      32'h1);

    // Arrival at the wrong floor is ignored; arrival at 5 opens the door for D cycles.
    bus.cab_floor  = 3'd3;
    bus.cab_arrive = 1'b1;
    tick();
    bus.cab_arrive = 1'b0;
    check("wrong_floor_door", 32'(bus.door_open), 32'h0);
    bus.cab_floor  = 3'd5;
    bus.cab_arrive = 1'b1;
    tick();
    bus.cab_arrive = 1'b0;
    check("arr_door",    32'(bus.door_open), 32'h1);
    check("arr_pending", 32'(bus.pending),   32'h00);
    count_door(door_len);
    check("door_len_5", 32'(door_len), 32'(D));

    // From floor 4 going up with calls at 0 and 2: reverse to 2, then 0.
    bus.cab_floor = 3'd4;
    bus.call_req  = 8'h05;
    tick();
    bus.call_req = '0;
    check("rev_pending", 32'(bus.pending), 32'h05);
    tick();
    tick();
    check("rev_valid", 32'(bus.tgt_valid), 32'h1);
    check("rev_floor", 32'(bus.tgt_floor), 32'h2);
    check("rev_dir",   32'(bus.dir_up),    32'h0);
    bus.tgt_ready = 1'b1;
    tick();
    bus.tgt_ready  = 1'b0;
    bus.cab_floor  = 3'd2;
    bus.cab_arrive = 1'b1;
    tick();
    bus.cab_arrive = 1'b0;
    check("f2_door",    32'(bus.door_open), 32'h1);
    check("f2_pending", 32'(bus.pending),   32'h01);
    tick();
    tick();
    bus.call_req = 8'h04;
    tick();
    bus.call_req = '0;
    check("f2_call_dropped", 32'(bus.pending), 32'h01);
    count_door(door_len);
    check("door_len_restart", 32'(door_len), 32'(D));
    tick();
    check("next_valid", 32'(bus.tgt_valid), 32'h1);
    check("next_floor", 32'(bus.tgt_floor), 32'h0);
    check("next_dir",   32'(bus.dir_up),    32'h0);

    // Asynchronous reset while offering a target.
    #2 rst = 1'b1;
    #1;
    check("arst_valid",   32'(bus.tgt_valid), 32'h0);
    check("arst_pending", 32'(bus.pending),   32'h00);
    check("arst_busy",    32'(bus.busy),      32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Randomized traffic with an erratic lift, plus occasional mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 7))
        0:       bus.call_req = N'(1 << $urandom_range(0, N - 1));
        1:       bus.call_req = N'($urandom) & N'($urandom);
        default: bus.call_req = '0;
      endcase
      bus.tgt_ready  = ($urandom_range(0, 2) != 0);
      bus.cab_arrive = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) bus.cab_floor = FW'($urandom_range(0, N - 1));
      else                           bus.cab_floor = FW'(m.tgt);
      if (c % 1000 == 999) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
